uart_echo_core: RTL and testbench

UART_ECHO_CORE -- requirements
Module: uart_echo_core

---
 rtl/uart_echo_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_echo_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_core.sv
// UART echo core: 8N1 receiver feeding a small FIFO that drains into an 8N1 transmitter.
// Serial input is ignored, and tx held idle, until a fixed boot delay after reset release.
module uart_echo_core #(
    parameter int BIT_CLKS    = 16,
    parameter int BOOT_CYCLES = 1000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic clock,
    input  logic resetb,
    input  logic rx,
    output logic tx,
    output logic ready,
    output logic framing_err,
    output logic overrun
);

    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [10:0] BIT_LAST  = 11'(BIT_CLKS - 1);
    localparam logic [10:0] HALF_LAST = 11'((BIT_CLKS / 2) - 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    logic              rx_meta_q;
    logic              rx_sync_q;
    logic [BOOT_W-1:0] boot_cnt_q;
    logic              ready_q;

    rx_state_e         rx_state_q;
    logic [10:0]       rx_cnt_q;
    logic [2:0]        rx_idx_q;
    logic [7:0]        rx_shreg_q;
    logic              framing_err_q;
    logic              overrun_q;

    tx_state_e         tx_state_q;
    logic [10:0]       tx_cnt_q;
    logic [2:0]        tx_idx_q;
    logic [7:0]        tx_shreg_q;
    logic              tx_q;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              fifo_empty_s;
    logic              fifo_full_s;

    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign tx          = tx_q;
    assign ready       = ready_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

    // Two-flop synchronizer for the asynchronous serial input, idling high.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Boot delay: ready latches high after the count completes.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            boot_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else if (!ready_q) begin
            if (boot_cnt_q == BOOT_LAST) begin
                ready_q <= 1'b1;
            end else begin
                boot_cnt_q <= boot_cnt_q + BOOT_W'(1);
            end
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Receiver FSM; owns the FIFO write side and the error pulses.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= 11'd0;
            rx_idx_q      <= 3'd0;
            rx_shreg_q    <= 8'h00;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= 11'd0;
                    if (ready_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                    end else begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                RX_START: begin
                    // Mid-start recheck rejects short glitches without flagging an error.
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= 11'd0;
                        rx_idx_q   <= 3'd0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 11'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= 11'd0;
                        rx_shreg_q <= {rx_sync_q, rx_shreg_q[7:1]};
                        if (rx_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 11'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= 11'd0;
                        rx_state_q <= RX_IDLE;
                        if (!rx_sync_q) begin
                            framing_err_q <= 1'b1;
                        end else if (fifo_full_s) begin
                            overrun_q <= 1'b1;
                        end else begin
                            mem_q[wr_ptr_q[AW-1:0]] <= rx_shreg_q;
                            wr_ptr_q                <= wr_ptr_q + PTR_ONE;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 11'd1;
                    end
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                    rx_cnt_q   <= 11'd0;
                end
            endcase
        end
    end

    // Transmitter FSM; owns the FIFO read side. A queued byte is taken straight
    // from the end of a stop bit so consecutive frames have no idle gap.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 11'd0;
            tx_idx_q   <= 3'd0;
            tx_shreg_q <= 8'h00;
            tx_q       <= 1'b1;
            rd_ptr_q   <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_cnt_q <= 11'd0;
                    if (ready_q && !fifo_empty_s) begin
                        tx_shreg_q <= mem_q[rd_ptr_q[AW-1:0]];
                        rd_ptr_q   <= rd_ptr_q + PTR_ONE;
                        tx_q       <= 1'b0;
                        tx_state_q <= TX_START;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= 11'd0;
                        tx_idx_q   <= 3'd0;
                        tx_q       <= tx_shreg_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 11'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= 11'd0;
                        if (tx_idx_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_q       <= tx_shreg_q[1];
                            tx_shreg_q <= {1'b0, tx_shreg_q[7:1]};
                            tx_idx_q   <= tx_idx_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 11'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= 11'd0;
                        if (!fifo_empty_s) begin
                            tx_shreg_q <= mem_q[rd_ptr_q[AW-1:0]];
                            rd_ptr_q   <= rd_ptr_q + PTR_ONE;
                            tx_q       <= 1'b0;
                            tx_state_q <= TX_START;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 11'd1;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    tx_q       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_core.sv
// Scoreboard bench for uart_echo_core: stimulus queues expected echo bytes,
// a serial monitor on tx decodes frames and pops/compares them.
module tb_uart_echo_core;

    localparam int BIT_CLKS    = 16;
    localparam int BOOT_CYCLES = 1000;
    localparam int FIFO_DEPTH  = 4;

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    logic rx     = 1'b1;
    logic tx;
    logic ready;
    logic framing_err;
    logic overrun;

    int errors   = 0;
    int checks   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int echo_cnt = 0;
    logic [7:0] exp_q[$];

    uart_echo_core #(
        .BIT_CLKS   (BIT_CLKS),
        .BOOT_CYCLES(BOOT_CYCLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .rx         (rx),
        .tx         (tx),
        .ready      (ready),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Error pulse counters
    always @(negedge clock) begin
        if (framing_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    // tx monitor: decode 8N1 frames sampled mid-bit and compare against the queue
    initial begin : monitor
        logic [7:0] data;
        logic       start_ok;
        logic       stop_ok;
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (tx === 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge clock);
                start_ok = (tx === 1'b0);
                for (int b = 0; b < 8; b++) begin
                    repeat (BIT_CLKS) @(negedge clock);
                    data[b] = tx;
                end
                repeat (BIT_CLKS) @(negedge clock);
                stop_ok = (tx === 1'b1);
                echo_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_echo: got 0x%0h expected no byte", data);
                end else begin
                    e = exp_q.pop_front();
                    check("echo_frame{start,stop,data}", {22'd0, start_ok, stop_ok, data},
                          {22'd0, 1'b1, 1'b1, e});
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
        hold(stop_bit, BIT_CLKS);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic boot_check(input string tag);
        int early = 0;
        int txlow = 0;
        for (int i = 0; i < BOOT_CYCLES - 1; i++) begin
            @(posedge clock);
            #1;
            if (ready !== 1'b0) early++;
            if (tx !== 1'b1) txlow++;
        end
        check({tag, "_ready_early"}, early, 0);
        check({tag, "_tx_idle_boot"}, txlow, 0);
        @(posedge clock);
        #1;
        check({tag, "_ready_at_boot"}, {31'd0, ready}, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int fe0;
        int ov0;
        int ec0;
        logic [7:0] hi [3];
        hi[0] = 8'h68; hi[1] = 8'h69; hi[2] = 8'h21;

        // Reset and boot
        #23;
        check("reset_outputs{tx,ready,fe,ov}", {28'd0, tx, ready, framing_err, overrun}, 4'b1000);
        @(negedge clock);
        resetb = 1'b1;
        boot_check("boot");

        // "hi!" back-to-back
        @(posedge clock); #1;
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(hi[i]);
            send_byte(hi[i], 1'b1);
        end
        wait_drain("hi_drain", 40 * BIT_CLKS);
        check("hi_framing_pulses", fe_cnt - fe0, 0);
        check("hi_overrun_pulses", ov_cnt - ov0, 0);

        // Framing error then a good byte
        fe0 = fe_cnt; ec0 = echo_cnt;
        send_byte(8'h55, 1'b0);
        hold(1'b1, 2 * BIT_CLKS);
        check("framing_pulse", fe_cnt - fe0, 1);
        check("framing_no_echo", echo_cnt - ec0, 0);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        wait_drain("a5_drain", 30 * BIT_CLKS);

        // Short start glitch
        hold(1'b1, 12 * BIT_CLKS);
        fe0 = fe_cnt; ec0 = echo_cnt;
        hold(1'b0, BIT_CLKS / 4);
        hold(1'b1, 20 * BIT_CLKS);
        check("glitch_framing", fe_cnt - fe0, 0);
        check("glitch_no_echo", echo_cnt - ec0, 0);
        check("glitch_tx_idle", {31'd0, tx}, 1);

        // Overrun: stall the transmitter in the stop bit of the first echo
        ov0 = ov_cnt; fe0 = fe_cnt; ec0 = echo_cnt;
        fork
            begin
                for (int i = 1; i <= FIFO_DEPTH + 2; i++) begin
                    if (i <= FIFO_DEPTH + 1) exp_q.push_back(8'(i));
                    send_byte(8'(i), 1'b1);
                end
            end
            begin
                int n = 0;
                while (tx !== 1'b0 && n < 30 * BIT_CLKS) begin
                    @(posedge clock); #1;
                    n++;
                end
                if (tx !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL ovr_echo_start: got no tx start expected start within budget");
                end else begin
                    repeat (9 * BIT_CLKS + 4) @(posedge clock);
                    #1;
                    force dut.tx_cnt_q = 11'd0;
                end
            end
        join
        hold(1'b1, 2 * BIT_CLKS);
        check("ovr_overrun_pulses", ov_cnt - ov0, 1);
        check("ovr_framing_pulses", fe_cnt - fe0, 0);
        release dut.tx_cnt_q;
        wait_drain("ovr_drain", 80 * BIT_CLKS);
        hold(1'b1, 12 * BIT_CLKS);
        check("ovr_echo_count", echo_cnt - ec0, FIFO_DEPTH + 1);

        // Reset during the 4th data bit of an incoming byte
        ec0 = echo_cnt;
        fork
            send_byte(8'h3C, 1'b1);
            begin
                repeat (BIT_CLKS * 4 + BIT_CLKS / 2) @(posedge clock);
                #3;
                resetb = 1'b0;
                #1;
                check("midframe_reset_outputs{tx,ready,fe,ov}",
                      {28'd0, tx, ready, framing_err, overrun}, 4'b1000);
                repeat (3) @(negedge clock);
                resetb = 1'b1;
                boot_check("reboot");
            end
        join
        hold(1'b1, 20 * BIT_CLKS);
        check("midframe_no_echo", echo_cnt - ec0, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
